// File: rtl/score_keeper.sv
// score_keeper: game state machine, BCD score with saturation, session
// high score and difficulty level for the dinosaur runner.
// All outputs come straight from registers. Any DUT state is visible on
// o_state (0 IDLE, 1 RUN, 2 PAUSED, 3 OVER).
module score_keeper #(
   parameter int NUM_DIGITS = 4,
   parameter int PERIOD     = 30,
   parameter int BONUS_PTS  = 5,
   parameter int LEVEL_STEP = 100,
   parameter int MAX_LEVEL  = 7,
   parameter int LEVEL_W    = 3
) (
   input  logic                      i_clk3,
   input  logic                      i_reset,
   input  logic                      i_start,
   input  logic                      i_pause,
   input  logic                      i_game_over,
   input  logic                      i_bonus,
   output logic [4*NUM_DIGITS-1:0]   o_score_bcd,
   output logic [4*NUM_DIGITS-1:0]   o_hiscore_bcd,
   output logic [LEVEL_W-1:0]        o_level,
   output logic                      o_level_up,
   output logic                      o_new_record,
   output logic [1:0]                o_state
);

   localparam int SW    = 4 * NUM_DIGITS;
   localparam int FW    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
   localparam int ACC_W = $clog2(LEVEL_STEP + 10) + 1;
   localparam logic [SW-1:0]      ALL_NINES  = {NUM_DIGITS{4'h9}};
   localparam logic [FW-1:0]      FRAME_LAST = FW'(PERIOD - 1);
   localparam logic [ACC_W-1:0]   STEP_VAL   = ACC_W'(LEVEL_STEP);
   localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(MAX_LEVEL);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_OVER   = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [SW-1:0]      r_score;
   logic [SW-1:0]      r_hiscore;
   logic [LEVEL_W-1:0] r_level;
   logic               r_level_up;
   logic               r_new_record;
   logic [FW-1:0]      r_frame;
   logic [ACC_W-1:0]   r_acc;

   logic               w_active;
   logic               w_tick;
   logic               w_bonus_ok;
   logic [3:0]         w_addend;
   logic [SW-1:0]      w_score_next;
   logic [ACC_W-1:0]   w_acc_sum;
   logic               w_level_hit;
   logic               w_enter_over;
   logic               w_restart;
   logic               w_saturated;

   // Tick/bonus qualification: game_over freezes the score on its final edge
   // so the high-score compare sees a settled value.
   always_comb begin
      w_active     = (r_state == ST_RUN) && !i_pause && !i_game_over;
      w_tick       = w_active && (r_frame == FRAME_LAST);
      w_bonus_ok   = (r_state == ST_RUN) && !i_game_over && i_bonus;
      w_addend     = {3'b000, w_tick} + (w_bonus_ok ? 4'(BONUS_PTS) : 4'd0);
      w_saturated  = (r_score == ALL_NINES);
      w_acc_sum    = r_acc + ACC_W'(w_addend);
      w_level_hit  = !w_saturated && (w_acc_sum >= STEP_VAL);
      w_enter_over = ((r_state == ST_RUN) || (r_state == ST_PAUSED)) && i_game_over;
      w_restart    = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && i_start;
   end

   // BCD add of the addend with ripple carry; a carry out of the top digit
   // pins the score at all nines instead of wrapping.
   always_comb begin
      logic [4:0] v_sum;
      logic [3:0] v_carry;
      logic [SW-1:0] v_res;
      v_carry = w_addend;
      v_res   = '0;
      v_sum   = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         v_sum = {1'b0, r_score[4*i +: 4]} + {1'b0, v_carry};
         if (v_sum >= 5'd10) begin
            v_res[4*i +: 4] = 4'(v_sum - 5'd10);
            v_carry         = 4'd1;
         end else begin
            v_res[4*i +: 4] = v_sum[3:0];
            v_carry         = 4'd0;
         end
      end
      w_score_next = (v_carry != 4'd0) ? ALL_NINES : v_res;
   end

   // Game state register.
   always_ff @(posedge i_clk3 or posedge i_reset) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_next;
   end

   // Next-state logic; game_over wins over pause and start.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (i_start) w_state_next = ST_RUN;
         ST_RUN: begin
            if (i_game_over)  w_state_next = ST_OVER;
            else if (i_pause) w_state_next = ST_PAUSED;
         end
         ST_PAUSED: begin
            if (i_game_over)   w_state_next = ST_OVER;
            else if (!i_pause) w_state_next = ST_RUN;
         end
         ST_OVER:   if (i_start) w_state_next = ST_RUN;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Score, frame counter, level accumulator and high-score bookkeeping.
   always_ff @(posedge i_clk3 or posedge i_reset) begin
      if (i_reset) begin
         r_score      <= '0;
         r_hiscore    <= '0;
         r_level      <= '0;
         r_level_up   <= 1'b0;
         r_new_record <= 1'b0;
         r_frame      <= '0;
         r_acc        <= '0;
      end else begin
         r_level_up <= 1'b0;
         if (w_restart) begin
            r_score      <= '0;
            r_level      <= '0;
            r_frame      <= '0;
            r_acc        <= '0;
            r_new_record <= 1'b0;
         end else if (r_state == ST_RUN) begin
            if (w_active) r_frame <= w_tick ? '0 : r_frame + FW'(1);
            r_score <= w_score_next;
            if (!w_saturated) begin
               if (w_level_hit) begin
                  r_acc <= w_acc_sum - STEP_VAL;
                  if (r_level != LEVEL_TOP) begin
                     r_level    <= r_level + LEVEL_W'(1);
                     r_level_up <= 1'b1;
                  end
               end else begin
                  r_acc <= w_acc_sum;
               end
            end
         end
         if (w_enter_over && (r_score > r_hiscore)) begin
            r_hiscore    <= r_score;
            r_new_record <= 1'b1;
         end
      end
   end

   assign o_score_bcd   = r_score;
   assign o_hiscore_bcd = r_hiscore;
   assign o_level       = r_level;
   assign o_level_up    = r_level_up;
   assign o_new_record  = r_new_record;
   assign o_state       = r_state;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus a randomized phase, all
// checked against an integer-arithmetic model of the scoring rules.
module tb_score_keeper;

   localparam int ND   = 2;
   localparam int PER  = 4;
   localparam int BON  = 5;
   localparam int STEP = 10;
   localparam int MAXL = 3;
   localparam int LW   = 2;
   localparam int MAXS = 99;

   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_OVER = 3;

   logic            i_clk3;
   logic            i_reset;
   logic            i_start;
   logic            i_pause;
   logic            i_game_over;
   logic            i_bonus;
   logic [4*ND-1:0] o_score_bcd;
   logic [4*ND-1:0] o_hiscore_bcd;
   logic [LW-1:0]   o_level;
   logic            o_level_up;
   logic            o_new_record;
   logic [1:0]      o_state;

   int total = 0;
   int bad   = 0;

   // model state: plain integers
   int m_state, m_score, m_hi, m_level, m_acc, m_active;
   bit m_lvup, m_rec;

   score_keeper #(
      .NUM_DIGITS(ND), .PERIOD(PER), .BONUS_PTS(BON),
      .LEVEL_STEP(STEP), .MAX_LEVEL(MAXL), .LEVEL_W(LW)
   ) dut (
      .i_clk3(i_clk3), .i_reset(i_reset), .i_start(i_start),
      .i_pause(i_pause), .i_game_over(i_game_over), .i_bonus(i_bonus),
      .o_score_bcd(o_score_bcd), .o_hiscore_bcd(o_hiscore_bcd),
      .o_level(o_level), .o_level_up(o_level_up),
      .o_new_record(o_new_record), .o_state(o_state)
   );

   // clock
   initial i_clk3 = 1'b0;
   always #5 i_clk3 = ~i_clk3;

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".state"},   32'(o_state),       32'(m_state));
      chk({tag, ".score"},   32'(o_score_bcd),   to_bcd(m_score));
      chk({tag, ".hiscore"}, 32'(o_hiscore_bcd), to_bcd(m_hi));
      chk({tag, ".level"},   32'(o_level),       32'(m_level));
      chk({tag, ".lvup"},    32'(o_level_up),    32'(m_lvup));
      chk({tag, ".record"},  32'(o_new_record),  32'(m_rec));
   endtask

   task automatic model_reset();
      m_state = S_IDLE; m_score = 0; m_hi = 0; m_level = 0;
      m_acc = 0; m_active = 0; m_lvup = 0; m_rec = 0;
   endtask

   // One clock of the game rules, written from the behavioural description.
   task automatic model_step(input bit s, input bit p, input bit g, input bit b);
      int add;
      bit tick;
      m_lvup = 0;
      add = 0;
      tick = 0;
      case (m_state)
         S_IDLE, S_OVER: begin
            if (s) begin
               m_state = S_RUN; m_score = 0; m_level = 0;
               m_acc = 0; m_active = 0; m_rec = 0;
            end
         end
         S_RUN: begin
            if (!g) begin
               if (!p) begin
                  m_active++;
                  tick = ((m_active % PER) == 0);
               end
               add = int'(tick) + (b ? BON : 0);
            end
            if (m_score != MAXS) begin
               m_acc += add;
               if (m_acc >= STEP) begin
                  m_acc -= STEP;
                  if (m_level < MAXL) begin
                     m_level++;
                     m_lvup = 1;
                  end
               end
            end
            m_score = (m_score + add > MAXS) ? MAXS : m_score + add;
            if (g) begin
               m_state = S_OVER;
               if (m_score > m_hi) begin m_hi = m_score; m_rec = 1; end
            end else if (p) begin
               m_state = S_PAUSED;
            end
         end
         default: begin
            if (g) begin
               m_state = S_OVER;
               if (m_score > m_hi) begin m_hi = m_score; m_rec = 1; end
            end else if (!p) begin
               m_state = S_RUN;
            end
         end
      endcase
   endtask

   // driver: apply inputs for one cycle, advance model, check #1 after edge
   task automatic step(input bit s, input bit p, input bit g, input bit b, input string tag);
      i_start = s; i_pause = p; i_game_over = g; i_bonus = b;
      @(posedge i_clk3);
      model_step(s, p, g, b);
      #1;
      chk_all(tag);
   endtask

   task automatic do_reset();
      i_start = 0; i_pause = 0; i_game_over = 0; i_bonus = 0;
      @(negedge i_clk3);
      i_reset = 1;
      model_reset();
      @(negedge i_clk3);
      i_reset = 0;
      chk_all("reset");
   endtask

   initial begin
      int lvup_seen;
      logic [31:0] score_at_lvup;
      int guard;
      i_reset = 0; i_start = 0; i_pause = 0; i_game_over = 0; i_bonus = 0;
      model_reset();

      // 1: 40 run cycles -> 10 points, one level_up at 09->10
      do_reset();
      step(1, 0, 0, 0, "t1_start");
      lvup_seen = 0;
      score_at_lvup = '0;
      for (int i = 0; i < 40; i++) begin
         step(0, 0, 0, 0, "t1_run");
         if (o_level_up) begin lvup_seen++; score_at_lvup = 32'(o_score_bcd); end
      end
      chk("t1_score", 32'(o_score_bcd), 32'h10);
      chk("t1_level", 32'(o_level), 32'd1);
      chk("t1_state", 32'(o_state), 32'd1);
      chk("t1_lvup_cnt", 32'(lvup_seen), 32'd1);
      chk("t1_lvup_at", score_at_lvup, 32'h10);

      // 2: pause holds frame counter
      do_reset();
      step(1, 0, 0, 0, "t2_start");
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, "t2_run");
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, "t2_pause");
      chk("t2_paused", 32'(o_state), 32'd2);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "t2_resume");
      chk("t2_score", 32'(o_score_bcd), 32'h02);
      chk("t2_state", 32'(o_state), 32'd1);

      // 3: bonus on the tick cycle at 04 -> 10 with carry and level_up
      do_reset();
      step(1, 0, 0, 0, "t3_start");
      for (int i = 0; i < 16; i++) step(0, 0, 0, 0, "t3_run");
      chk("t3_score4", 32'(o_score_bcd), 32'h04);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, "t3_run");
      step(0, 0, 0, 1, "t3_bonus");
      chk("t3_score", 32'(o_score_bcd), 32'h10);
      chk("t3_lvup", 32'(o_level_up), 32'd1);

      // 4: climb to 97, bonus saturates at 99, level capped
      guard = 0;
      while (m_score < 90 && guard < 500) begin step(0, 0, 0, 1, "t4_climb"); guard++; end
      while (m_score < 97 && guard < 1000) begin step(0, 0, 0, 0, "t4_tick"); guard++; end
      chk("t4_guard", 32'(guard < 1000), 32'd1);
      chk("t4_score97", 32'(o_score_bcd), 32'h97);
      step(0, 0, 0, 1, "t4_bonus");
      chk("t4_sat", 32'(o_score_bcd), 32'h99);
      for (int i = 0; i < 12; i++) step(0, 0, 0, (i % 3) == 0, "t4_hold");
      chk("t4_hold", 32'(o_score_bcd), 32'h99);
      chk("t4_level", 32'(o_level), 32'd3);

      // 5: high score capture and no-record second run
      do_reset();
      step(1, 0, 0, 0, "t5_start");
      for (int i = 0; i < 48; i++) step(0, 0, 0, 0, "t5_run");
      step(0, 0, 1, 0, "t5_over");
      chk("t5_state", 32'(o_state), 32'd3);
      chk("t5_hi", 32'(o_hiscore_bcd), 32'h12);
      chk("t5_rec", 32'(o_new_record), 32'd1);
      step(1, 0, 0, 0, "t5_restart");
      chk("t5_score0", 32'(o_score_bcd), 32'h00);
      chk("t5_rec0", 32'(o_new_record), 32'd0);
      chk("t5_hi_kept", 32'(o_hiscore_bcd), 32'h12);
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, "t5_run2");
      step(0, 0, 1, 0, "t5_over2");
      chk("t5_hi2", 32'(o_hiscore_bcd), 32'h12);
      chk("t5_rec2", 32'(o_new_record), 32'd0);

      // 6: game_over beats pause; async reset without a clock edge
      step(1, 0, 0, 0, "t6_start");
      for (int i = 0; i < 9; i++) step(1, 0, 0, 0, "t6_run");
      chk("t6_run_start_held", 32'(o_state), 32'd1);
      step(0, 1, 1, 0, "t6_over");
      chk("t6_state", 32'(o_state), 32'd3);
      step(1, 0, 0, 0, "t6_start2");
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1, "t6_run2");
      @(negedge i_clk3);
      #2;
      i_reset = 1;
      model_reset();
      #1;
      chk("t6_ares_state", 32'(o_state), 32'd0);
      chk("t6_ares_score", 32'(o_score_bcd), 32'd0);
      chk("t6_ares_hi", 32'(o_hiscore_bcd), 32'd0);
      chk("t6_ares_level", 32'(o_level), 32'd0);
      chk("t6_ares_rec", 32'(o_new_record), 32'd0);
      @(negedge i_clk3);
      i_reset = 0;

      // random phase
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 99) < 8,
              $urandom_range(0, 99) < 12,
              $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 25,
              "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
